// File: rtl/shift_buffer_arbiter.sv
// shift_buffer_arbiter: grants the shared shift-buffer input to one requester
// for a whole BURST_LEN-word frame, waits for the buffer's frame-complete
// pulse, tags the frame with its source, then re-arbitrates round-robin.
module shift_buffer_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk_data,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  output logic [DATA_W-1:0]         buf_data_o,
  output logic                      buf_wr_en_o,
  input  logic                      buf_valid_i,
  output logic [$clog2(N_REQ)-1:0]  frame_src_o,
  output logic                      frame_done_o,
  output logic                      busy_o,
  output logic                      timeout_err_o,
  input  logic                      err_clr_i
);

  localparam int SRC_W = $clog2(N_REQ);
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t             state_r;
  logic [SRC_W-1:0]   grant_r;
  logic [SRC_W-1:0]   last_grant_r;
  logic [CNT_W-1:0]   word_cnt_r;
  logic [TMR_W-1:0]   timer_r;

  logic [SRC_W-1:0]   pick_s;
  logic               found_s;
  logic               xfer_s;
  logic [DATA_W-1:0]  sel_data_s;

  // Round-robin search: first valid requester after last_grant, wrapping.
  always_comb begin
    pick_s  = last_grant_r;
    found_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!found_s && req_valid_i[(int'(last_grant_r) + k) % N_REQ]) begin
        pick_s  = SRC_W'((int'(last_grant_r) + k) % N_REQ);
        found_s = 1'b1;
      end else begin
        pick_s  = pick_s;
      end
    end
  end

  // Only the granted requester is readied, and only while bursting.
  always_comb begin
    req_ready_o = '0;
    if (state_r == BURST) begin
      req_ready_o[grant_r] = 1'b1;
    end else begin
      req_ready_o = '0;
    end
  end

  assign xfer_s     = |(req_valid_i & req_ready_o);
  assign sel_data_s = req_data_i[int'(grant_r) * DATA_W +: DATA_W];
  assign busy_o     = (state_r != IDLE);

  // Arbitration FSM with all buffer-side and status outputs registered.
  always_ff @(posedge clk_data) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      last_grant_r  <= SRC_W'(N_REQ - 1);
      word_cnt_r    <= '0;
      timer_r       <= '0;
      buf_data_o    <= '0;
      buf_wr_en_o   <= 1'b0;
      frame_src_o   <= '0;
      frame_done_o  <= 1'b0;
      timeout_err_o <= 1'b0;
    end else begin
      buf_wr_en_o  <= 1'b0;
      frame_done_o <= 1'b0;
      // A clear is overridden below if a timeout fires on the same edge.
      if (err_clr_i) begin
        timeout_err_o <= 1'b0;
      end else begin
        timeout_err_o <= timeout_err_o;
      end
      case (state_r)
        IDLE: begin
          if (found_s) begin
            grant_r    <= pick_s;
            word_cnt_r <= '0;
            state_r    <= BURST;
          end else begin
            state_r    <= IDLE;
          end
        end
        BURST: begin
          if (xfer_s) begin
            buf_data_o  <= sel_data_s;
            buf_wr_en_o <= 1'b1;
            if (word_cnt_r == CNT_W'(BURST_LEN - 1)) begin
              word_cnt_r <= '0;
              timer_r    <= '0;
              state_r    <= WAIT;
            end else begin
              word_cnt_r <= word_cnt_r + CNT_W'(1);
            end
          end else begin
            buf_wr_en_o <= 1'b0;
          end
        end
        WAIT: begin
          // A frame pulse on the expiry cycle still counts as a good frame.
          if (buf_valid_i) begin
            frame_src_o  <= grant_r;
            frame_done_o <= 1'b1;
            last_grant_r <= grant_r;
            state_r      <= IDLE;
          end else if (timer_r == TMR_W'(TIMEOUT - 1)) begin
            timeout_err_o <= 1'b1;
            last_grant_r  <= grant_r;
            state_r       <= IDLE;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_buffer_arbiter.sv
// Testbench for shift_buffer_arbiter: a directed vector table, hand-written
// corner sequences, and random traffic checked against a frame-level model.
module tb_shift_buffer_arbiter;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int BL  = 8;
  localparam int TO  = 16;

  logic            clk_data = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*W-1:0]  req_data = '0;
  logic [N-1:0]    req_ready;
  logic [W-1:0]    buf_data;
  logic            buf_wr_en;
  logic            buf_valid = 1'b0;
  logic [1:0]      frame_src;
  logic            frame_done;
  logic            busy;
  logic            timeout_err;
  logic            err_clr = 1'b0;

  int total = 0;
  int bad   = 0;

  shift_buffer_arbiter #(.N_REQ(N), .DATA_W(W), .BURST_LEN(BL), .TIMEOUT(TO)) dut (
    .clk_data(clk_data), .rst(rst), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .buf_data_o(buf_data), .buf_wr_en_o(buf_wr_en),
    .buf_valid_i(buf_valid), .frame_src_o(frame_src), .frame_done_o(frame_done),
    .busy_o(busy), .timeout_err_o(timeout_err), .err_clr_i(err_clr)
  );

  always #5 clk_data = ~clk_data;

  // Reference model: mode 0 idle, 1 bursting, 2 waiting for the frame pulse.
  int          m_mode = 0;
  int          m_grant = 0;
  int          m_last = N - 1;
  int          m_words = 0;
  int          m_wait = 0;
  logic [W-1:0] m_data = '0;
  logic        m_wr = 1'b0;
  int          m_src = 0;
  logic        m_done = 1'b0;
  logic        m_err = 1'b0;

  function automatic int rr_pick(int last, logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update();
    logic next_err;
    int   p;
    if (rst) begin
      m_mode = 0; m_grant = 0; m_last = N - 1; m_words = 0; m_wait = 0;
      m_data = '0; m_wr = 1'b0; m_src = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_wr = 1'b0;
      m_done = 1'b0;
      next_err = err_clr ? 1'b0 : m_err;
      if (m_mode == 0) begin
        p = rr_pick(m_last, req_valid);
        if (p >= 0) begin m_grant = p; m_mode = 1; m_words = 0; end
      end else if (m_mode == 1) begin
        if (req_valid[m_grant]) begin
          m_wr = 1'b1;
          m_data = req_data[m_grant*W +: W];
          m_words++;
          if (m_words == BL) begin m_mode = 2; m_words = 0; m_wait = 0; end
        end
      end else begin
        if (buf_valid) begin
          m_src = m_grant; m_done = 1'b1; m_last = m_grant; m_mode = 0;
        end else if (m_wait == TO - 1) begin
          next_err = 1'b1; m_last = m_grant; m_mode = 0;
        end else begin
          m_wait++;
        end
      end
      m_err = next_err;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: combinational checks before the edge, registered ones after.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    #1;
    if (!rst) begin
      exp_ready = (m_mode == 1) ? (N'(1) << m_grant) : '0;
      chk("ready", req_ready, exp_ready);
      chk("busy", busy, m_mode != 0);
    end
    @(posedge clk_data);
    model_update();
    #1;
    chk("wr_en", buf_wr_en, m_wr);
    chk("data", buf_data, m_data);
    chk("done", frame_done, m_done);
    chk("src", frame_src, m_src);
    chk("err", timeout_err, m_err);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; buf_valid = 1'b0; err_clr = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic rand_data();
    req_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic run_to_wait();
    int n = 0;
    while (m_mode != 2 && n < 40) begin rand_data(); cycle(); n++; end
    chk("reach_wait", m_mode, 2);
  endtask

  typedef struct {
    logic         rst;
    logic [N-1:0] valid;
    logic [W-1:0] word;
    logic         bv;
    logic [N-1:0] e_ready;
    logic         e_busy;
    logic         e_wr;
    logic [W-1:0] e_data;
    logic         e_done;
    logic [1:0]   e_src;
    logic         e_err;
  } vec_t;

  vec_t vecs[14];

  initial begin
    int frames, writes, bub, n;
    logic seen_done;
    logic [N-1:0] v;

    // Single requester 2 frame, every cycle hand-derived.
    vecs[0] = '{1'b1, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 4'b0100, 32'h10, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0};
    for (int i = 0; i < 8; i++)
      vecs[2+i] = '{1'b0, 4'b0100, 32'h10 + 32'(i), 1'b0, 4'b0100, 1'b1, 1'b1,
                    32'h10 + 32'(i), 1'b0, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h17, 1'b0, 2'd0, 1'b0};
    vecs[11] = vecs[10];
    vecs[12] = '{1'b0, 4'b0000, 32'h0, 1'b1, 4'b0000, 1'b1, 1'b0, 32'h17, 1'b1, 2'd2, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 32'h0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h17, 1'b0, 2'd2, 1'b0};

    for (int i = 0; i < 14; i++) begin
      rst = vecs[i].rst; req_valid = vecs[i].valid; buf_valid = vecs[i].bv;
      req_data = '0;
      req_data[2*W +: W] = vecs[i].word;
      #1;
      if (!vecs[i].rst) begin
        chk("t_ready", req_ready, vecs[i].e_ready);
        chk("t_busy", busy, vecs[i].e_busy);
      end
      @(posedge clk_data);
      model_update();
      #1;
      chk("t_wr", buf_wr_en, vecs[i].e_wr);
      chk("t_data", buf_data, vecs[i].e_data);
      chk("t_done", frame_done, vecs[i].e_done);
      chk("t_src", frame_src, vecs[i].e_src);
      chk("t_err", timeout_err, vecs[i].e_err);
    end

    // Fairness: all valid, grants must rotate 0,1,2,3.
    do_reset();
    req_valid = 4'hF; frames = 0; n = 0;
    while (frames < 4 && n < 200) begin
      buf_valid = (m_mode == 2 && m_wait == 2);
      rand_data(); cycle(); n++;
      if (frame_done) begin chk("rr_order", frame_src, frames); frames++; end
    end
    chk("rr_frames", frames, 4);

    // Bubbles: requester 1 drops valid for 3 cycles after its 4th word.
    do_reset();
    frames = 0; writes = 0; bub = 0; n = 0;
    while (frames < 2 && n < 300) begin
      v = 4'b0011;
      if (m_mode == 1 && m_grant == 1 && m_words == 4 && bub < 3) begin v[1] = 1'b0; bub++; end
      req_valid = v;
      buf_valid = (m_mode == 2 && m_wait == 2);
      rand_data(); cycle(); n++;
      if (buf_wr_en && frames == 1) writes++;
      if (frame_done) begin
        if (frames == 1) chk("bubble_src", frame_src, 1);
        frames++;
      end
    end
    chk("bubble_writes", writes, 8);
    chk("bubble_gaps", bub, 3);

    // Timeout: error rises exactly TO cycles after WAIT entry.
    do_reset();
    req_valid = 4'b0001; buf_valid = 1'b0;
    run_to_wait();
    req_valid = '0; n = 0; seen_done = 1'b0;
    while (!timeout_err && n < 40) begin
      cycle(); n++;
      if (frame_done) seen_done = 1'b1;
    end
    chk("timeout_cycles", n, TO);
    chk("timeout_no_done", seen_done, 1'b0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    chk("err_clr", timeout_err, 1'b0);
    req_valid = 4'b0001;
    run_to_wait();
    req_valid = '0; err_clr = 1'b1; n = 0;
    while (m_mode != 0 && n < 40) begin cycle(); n++; end
    err_clr = 1'b0;
    chk("set_wins", timeout_err, 1'b1);

    // Frame pulse coincident with expiry wins.
    do_reset();
    req_valid = 4'b0001;
    run_to_wait();
    req_valid = '0;
    repeat (TO - 1) cycle();
    buf_valid = 1'b1; cycle(); buf_valid = 1'b0;
    chk("coinc_done", frame_done, 1'b1);
    chk("coinc_err", timeout_err, 1'b0);

    // Stray frame pulse in IDLE is ignored.
    do_reset();
    buf_valid = 1'b1;
    repeat (3) begin cycle(); chk("stray_done", frame_done, 1'b0); end
    buf_valid = 1'b0;

    // Reset at word 5 aborts; next arbitration starts from requester 0.
    do_reset();
    req_valid = 4'b0100; n = 0;
    while (!(m_mode == 1 && m_words == 5) && n < 40) begin rand_data(); cycle(); n++; end
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("rst_data", buf_data, 32'h0);
    chk("rst_wr", buf_wr_en, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", req_ready, 4'b0000);
    req_valid = 4'hF; cycle();
    chk("rst_regrant", req_ready, 4'b0001);
    n = 0;
    while (!frame_done && n < 60) begin
      buf_valid = (m_mode == 2 && m_wait == 1);
      rand_data(); cycle(); n++;
    end
    buf_valid = 1'b0;
    chk("rst_frame_src", frame_src, 2'd0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      req_valid = N'($urandom);
      buf_valid = ($urandom_range(0, 7) == 0);
      err_clr = ($urandom_range(0, 15) == 0);
      rand_data();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shift_buffer_arbiter.md
Name: shift_buffer_arbiter

Overview:
- Shares the single 32-bit shift buffer input between N_REQ word-stream requesters.
- Grants the buffer to one requester for exactly one BURST_LEN-word frame, so a 256-bit frame never mixes sources.
- Waits for the buffer's frame-valid pulse, tags the completed frame with its source ID, then re-arbitrates round-robin.
- Sits between the input DMA/requester ports and the shift buffer, in the clk_data domain.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 32, word width; must match the buffer input width.
- BURST_LEN, 8, words per frame; must match the buffer frame size.
- TIMEOUT, 16, maximum cycles in WAIT for buf_valid_i before an error is flagged.

Ports:
- clk_data  in  1  clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid_i  in  N_REQ  per-requester word valid.
- req_data_i  in  N_REQ*DATA_W  per-requester word; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready_o  out  N_REQ  per-requester accept (valid&ready = word transferred).
- buf_data_o  out  DATA_W  word to the shift buffer.
- buf_wr_en_o  out  1  write strobe to the shift buffer.
- buf_valid_i  in  1  frame-complete pulse from the shift buffer.
- frame_src_o  out  clog2(N_REQ)  requester ID of the last completed frame.
- frame_done_o  out  1  1-cycle pulse; frame_src_o is valid while it is high.
- busy_o  out  1  high when the state is not IDLE.
- timeout_err_o  out  1  sticky error flag: WAIT expired without buf_valid_i.
- err_clr_i  in  1  clears timeout_err_o.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, word_cnt=0, timer=0, last_grant=N_REQ-1.
  - All outputs are 0: buf_data_o, buf_wr_en_o, frame_src_o, frame_done_o, timeout_err_o.
  - req_ready_o is 0 and busy_o is 0, because both are decoded from state.
  - Reset mid-burst or mid-WAIT aborts immediately with no frame_done_o pulse.
  - System rule: the shift buffer is reset in the same cycle.
- States: IDLE, BURST, WAIT.
- IDLE:
  - If any req_valid_i is high, pick the first requester with valid high, searching from last_grant+1 upward and wrapping modulo N_REQ.
  - Register the choice as grant and go to BURST. Grant latency is 1 cycle; no word is accepted in IDLE.
  - If no req_valid_i is high, stay in IDLE.
- BURST:
  - req_ready_o[grant]=1, combinational from state and grant. All other ready bits are 0.
  - On a transfer (valid&ready), the next edge loads buf_data_o<=req_data_i[grant] and buf_wr_en_o<=1. Otherwise buf_wr_en_o<=0.
  - buf_data_o holds its last value when buf_wr_en_o is 0.
  - Latency from transfer to buf_wr_en_o is exactly 1 cycle.
  - word_cnt increments per transfer, 0..BURST_LEN-1.
  - The transfer with word_cnt=BURST_LEN-1 resets word_cnt to 0, clears the timer and moves to WAIT.
  - The granted requester may drop valid mid-burst (bubbles). The grant is held regardless; no preemption and no burst abort.
  - Non-granted requesters are never readied.
- WAIT:
  - The timer increments every cycle from 0.
  - buf_valid_i=1 ends WAIT: next edge sets frame_src_o<=grant, frame_done_o<=1 for one cycle, last_grant<=grant, and state goes to IDLE.
  - If timer==TIMEOUT-1 and buf_valid_i=0, the next edge sets timeout_err_o<=1, last_grant<=grant and state goes to IDLE, with no frame_done_o.
  - If buf_valid_i and expiry coincide, buf_valid_i wins.
- buf_valid_i seen in IDLE or BURST is ignored; it produces no frame_done_o.
- frame_src_o holds its value until the next frame_done_o.
- timeout_err_o:
  - err_clr_i=1 clears it on the next edge.
  - If a timeout set and err_clr_i occur on the same edge, set wins.
  - After a timeout, frame alignment in the buffer is undefined; recovery is rst.
- Back-to-back frames: the minimum frame period is 1 (IDLE) + BURST_LEN + WAIT duration.
- Round-robin fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0.

Test Plan:
- Single requester: reset, req_valid_i=4'b0100 with data 0x10..0x17, model buffer pulses buf_valid_i 2 cycles after the 8th write -> 8 buf_wr_en_o pulses carrying 0x10..0x17 in order, each 1 cycle after its transfer; then frame_done_o=1 with frame_src_o=2; busy_o returns to 0.
- Fairness: all four requesters continuously valid for 4 frames -> grant order 0,1,2,3; req_ready_o is one-hot in BURST and 0 in IDLE/WAIT.
- Bubbles: granted requester 1 deasserts valid for 3 cycles after word 4 while requester 0 stays valid -> grant held on 1, req_ready_o[0]=0 throughout, exactly 8 writes, frame_src_o=1.
- Timeout: no buf_valid_i after the burst, TIMEOUT=16 -> timeout_err_o rises exactly 16 cycles after WAIT entry with no frame_done_o; err_clr_i pulse clears it; a coincident set and clear leaves it at 1.
- Edge cases:
  - buf_valid_i on the same cycle as expiry -> frame_done_o=1, timeout_err_o stays 0.
  - Stray buf_valid_i in IDLE -> no frame_done_o.
- Reset at word 5 of a burst -> next cycle all outputs 0 and state IDLE; a following burst starts from word_cnt=0 and grants requester 0 first.
